branch_history_predictor: RTL and testbench
===========================================

BRANCH_HISTORY_PREDICTOR -- requirements
Module: branch_history_predictor

Interface
REQ-001 Parameter XLEN, default 32: address/immediate width.
REQ-002 Parameter ENTRIES, default 64: branch history table depth; SHALL be a power of two, >= 2.
REQ-003 Parameter STAT_WIDTH, default 16: misprediction counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pc  input  XLEN  address of the instruction being predicted.
REQ-007 immediate  input  XLEN  sign-extended branch/jump offset.
REQ-008 jump  input  1  instruction is an unconditional jump.
REQ-009 branch  input  1  instruction is a conditional branch.
REQ-010 static_mode  input  1  1 = backward-taken/forward-not-taken prediction; 0 = table prediction.
REQ-011 update_valid  input  1  a conditional branch resolved this cycle.
REQ-012 update_pc  input  XLEN  address of the resolved branch.
REQ-013 update_taken  input  1  resolved outcome from the branch evaluator.
REQ-014 update_mispredicted  input  1  resolved outcome differed from its prediction.
REQ-015 branch_target  output  XLEN  predicted target address.
REQ-016 branch_taken  output  1  prediction: redirect fetch to branch_target.
REQ-017 mispredict_count  output  STAT_WIDTH  resolved-mispredictions counter.

Function
REQ-018 branch_target SHALL equal (pc + immediate) mod 2^XLEN, combinationally, regardless of control inputs.
REQ-019 Table index SHALL be pc[log2(ENTRIES)+1:2]; update index SHALL be update_pc[log2(ENTRIES)+1:2]; aliasing PCs share one entry.
REQ-020 Each entry SHALL be a 2-bit saturating counter: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
REQ-021 branch_taken SHALL be combinational: 1 if jump; else, if branch and static_mode, immediate[XLEN-1]; else, if branch, counter[1] of the indexed entry; else 0.
REQ-022 jump SHALL take precedence over branch when both are asserted.
REQ-023 On a rising clk with update_valid=1: update_taken=1 increments the indexed counter, saturating at STRONG_T; update_taken=0 decrements it, saturating at STRONG_NT.
REQ-024 Updates SHALL occur regardless of static_mode, so that the table trains while static prediction is in use.
REQ-025 Read during a same-cycle write to the same index SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-026 update_valid=0 SHALL leave the table and mispredict_count unchanged.
REQ-027 mispredict_count SHALL increment by 1 on each clk with update_valid=1 and update_mispredicted=1, wrapping from 2^STAT_WIDTH-1 to 0.
REQ-028 update_mispredicted SHALL be ignored when update_valid=0.

Reset
REQ-029 Reset assertion SHALL immediately (asynchronously) set every table entry to WEAK_NT and mispredict_count to 0.
REQ-030 While reset is held, updates SHALL be ignored; outputs SHALL remain combinational from the reset state (branch_taken for a table-mode branch = 0).
REQ-031 Reset asserted mid-training SHALL discard all history; the first edge after deassertion behaves as from power-up.

Structure
REQ-032 The shared package branch_pkg SHALL hold the counter enum typedef (sc_state_t) and a pure function for the saturating next-state.
REQ-033 One sub-module, saturating_counter (2-bit, inc/dec/enable, async reset to WEAK_NT), SHALL be instantiated ENTRIES times via generate; the top level holds the index decode, prediction mux and statistics counter.

Verification (ENTRIES=64, XLEN=32)
REQ-034 After reset: pc=0x104, branch=1, static_mode=0, immediate=20 -> branch_taken=0, branch_target=0x118.
REQ-035 Two cycles of update_valid=1, update_pc=0x104, update_taken=1 -> branch_taken=1 for pc=0x104 from the following cycle; entry=STRONG_T. One not-taken update -> still 1 (WEAK_T); a second -> 0.
REQ-036 Four taken updates on 0x104 -> saturated at STRONG_T; then predict pc=0x204 (alias, index 1) -> branch_taken=1; pc=0x108 -> 0.
REQ-037 static_mode=1, branch=1, immediate=-4 -> taken; immediate=20 -> not taken, independent of table contents; jump=1 with branch=1 -> taken.
REQ-038 Same-cycle update_taken=1 and predict on index 1 from WEAK_NT -> predict 0 that cycle, 1 the next.
REQ-039 STAT_WIDTH=4: 17 mispredicted updates -> mispredict_count=1; assert reset mid-run -> count=0 and pc=0x104 predicts 0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch history predictor: 2-bit counter encoding and
// its saturating next-state function.
package branch_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } sc_state_t;

  function automatic sc_state_t sc_next(input sc_state_t cur, input logic taken);
    sc_state_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != STRONG_T) nxt = sc_state_t'(cur + 2'd1);
    end else begin
      if (cur != STRONG_NT) nxt = sc_state_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// One branch history entry: 2-bit saturating counter that moves toward taken
// or not-taken when enabled, reset to weakly not-taken.
module saturating_counter
  import branch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      inc,
  output sc_state_t state
);

  sc_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = sc_next(state_q, inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WEAK_NT;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/branch_history_predictor.sv
// Branch predictor: table of 2-bit counters indexed by pc word address, with a
// static BTFN fallback mode and a resolved-misprediction statistics counter.
module branch_history_predictor
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENTRIES    = 64,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       immediate,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  static_mode,
  input  logic                  update_valid,
  input  logic [XLEN-1:0]       update_pc,
  input  logic                  update_taken,
  input  logic                  update_mispredicted,
  output logic [XLEN-1:0]       branch_target,
  output logic                  branch_taken,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]      pred_idx;
  logic [IDX_W-1:0]      upd_idx;
  sc_state_t             ctr_state [ENTRIES];
  sc_state_t             pred_state;
  logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic                  unused_upd_pc_bits;

  // Instructions are word aligned, so the low two pc bits carry no information.
  assign pred_idx = pc[IDX_W+1:2];
  assign upd_idx  = update_pc[IDX_W+1:2];
  assign unused_upd_pc_bits = ^{update_pc[XLEN-1:IDX_W+2], update_pc[1:0]};

  assign branch_target = pc + immediate;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic upd_en;
      assign upd_en = update_valid && (upd_idx == IDX_W'(gi));
      saturating_counter u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (upd_en),
        .inc   (update_taken),
        .state (ctr_state[gi])
      );
    end
  endgenerate

  // Reads the registered counter, so a same-cycle update is seen one cycle later.
  always_comb begin
    pred_state   = ctr_state[pred_idx];
    branch_taken = 1'b0;
    if (jump) begin
      branch_taken = 1'b1;
    end else if (branch) begin
      if (static_mode) branch_taken = immediate[XLEN-1];
      else             branch_taken = pred_state[1];
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (update_valid && update_mispredicted)
      mispredict_count_d = mispredict_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mispredict_count_q <= '0;
    else       mispredict_count_q <= mispredict_count_d;
  end

  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed-vector bench for branch_history_predictor (ENTRIES=64, XLEN=32,
// STAT_WIDTH=4) with hand-computed expectations.
module tb_branch_history_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] immediate;
  logic        jump;
  logic        branch;
  logic        static_mode;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_mispredicted;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [3:0]  mispredict_count;

  int n_vec;
  int n_err;

  branch_history_predictor #(
    .XLEN       (32),
    .ENTRIES    (64),
    .STAT_WIDTH (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pc                  (pc),
    .immediate           (immediate),
    .jump                (jump),
    .branch              (branch),
    .static_mode         (static_mode),
    .update_valid        (update_valid),
    .update_pc           (update_pc),
    .update_taken        (update_taken),
    .update_mispredicted (update_mispredicted),
    .branch_target       (branch_target),
    .branch_taken        (branch_taken),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One resolved-branch update applied across a single rising edge.
  task automatic upd(input logic [31:0] a, input logic t, input logic m);
    update_valid        = 1'b1;
    update_pc           = a;
    update_taken        = t;
    update_mispredicted = m;
    step();
    update_valid        = 1'b0;
    update_mispredicted = 1'b0;
    #1;
  endtask

  task automatic predict(input logic [31:0] a, input logic [31:0] imm);
    pc        = a;
    immediate = imm;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pc = 32'h104; immediate = 32'd20;
    jump = 1'b0; branch = 1'b1; static_mode = 1'b0;
    update_valid = 1'b0; update_pc = 32'h0;
    update_taken = 1'b0; update_mispredicted = 1'b0;
    step();
    step();

    // Updates held off while in reset
    update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b1; update_mispredicted = 1'b1;
    step();
    update_valid = 1'b0; update_mispredicted = 1'b0;
    #1;
    check("rst_count", 32'(mispredict_count), 32'd0);
    check("rst_taken", 32'(branch_taken), 32'd0);
    check("rst_target", branch_target, 32'h118);

    reset = 1'b0;
    step();
    check("init_taken_104", 32'(branch_taken), 32'd0);
    check("init_target_104", branch_target, 32'h118);

    // Same-cycle update and predict on index 1: pre-update value this cycle
    update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b1;
    #1;
    check("same_cycle_old", 32'(branch_taken), 32'd0);
    step();
    update_valid = 1'b0;
    #1;
    check("same_cycle_new", 32'(branch_taken), 32'd1);

    upd(32'h104, 1'b1, 1'b0);
    check("strong_t", 32'(branch_taken), 32'd1);
    upd(32'h104, 1'b0, 1'b0);
    check("weak_t", 32'(branch_taken), 32'd1);
    upd(32'h104, 1'b0, 1'b0);
    check("weak_nt", 32'(branch_taken), 32'd0);

    // update_valid low must not train
    update_valid = 1'b0; update_pc = 32'h104; update_taken = 1'b1; update_mispredicted = 1'b1;
    step();
    step();
    update_mispredicted = 1'b0;
    check("no_valid_taken", 32'(branch_taken), 32'd0);
    check("no_valid_count", 32'(mispredict_count), 32'd0);

    for (int i = 0; i < 4; i++) upd(32'h104, 1'b1, 1'b0);
    predict(32'h204, 32'd20);
    check("alias_204", 32'(branch_taken), 32'd1);
    predict(32'h108, 32'd20);
    check("idx2_108", 32'(branch_taken), 32'd0);
    // Saturated at STRONG_T: one decrement leaves WEAK_T
    predict(32'h104, 32'd20);
    upd(32'h104, 1'b0, 1'b0);
    check("sat_dec1", 32'(branch_taken), 32'd1);
    upd(32'h104, 1'b0, 1'b0);
    check("sat_dec2", 32'(branch_taken), 32'd0);
    // Saturation at STRONG_NT
    for (int i = 0; i < 3; i++) upd(32'h104, 1'b0, 1'b0);
    upd(32'h104, 1'b1, 1'b0);
    check("sat_nt_inc1", 32'(branch_taken), 32'd0);
    upd(32'h104, 1'b1, 1'b0);
    check("sat_nt_inc2", 32'(branch_taken), 32'd1);
    upd(32'h104, 1'b0, 1'b0);
    upd(32'h104, 1'b0, 1'b0);

    // Static mode, with table training continuing underneath
    static_mode = 1'b1;
    predict(32'h108, 32'hFFFF_FFFC);
    check("static_back", 32'(branch_taken), 32'd1);
    check("static_back_tgt", branch_target, 32'h104);
    upd(32'h108, 1'b1, 1'b0);
    upd(32'h108, 1'b1, 1'b0);
    predict(32'h108, 32'd20);
    check("static_fwd", 32'(branch_taken), 32'd0);
    static_mode = 1'b0;
    #1;
    check("trained_in_static", 32'(branch_taken), 32'd1);

    jump = 1'b1;
    predict(32'h104, 32'd20);
    check("jump_and_branch", 32'(branch_taken), 32'd1);
    branch = 1'b0;
    #1;
    check("jump_only", 32'(branch_taken), 32'd1);
    jump = 1'b0;
    predict(32'h108, 32'd20);
    check("no_branch", 32'(branch_taken), 32'd0);
    branch = 1'b1;
    predict(32'hFFFF_FFFC, 32'd8);
    check("target_wrap", branch_target, 32'h4);

    // Statistics: 17 mispredicts wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) upd(32'h300, 1'b0, 1'b1);
    check("count_wrap", 32'(mispredict_count), 32'd1);
    update_valid = 1'b0; update_mispredicted = 1'b1;
    step();
    update_mispredicted = 1'b0;
    check("count_ignored", 32'(mispredict_count), 32'd1);
    upd(32'h300, 1'b1, 1'b1);
    check("count_two", 32'(mispredict_count), 32'd2);

    // Mid-run asynchronous reset discards history
    predict(32'h104, 32'd20);
    upd(32'h104, 1'b1, 1'b0);
    upd(32'h104, 1'b1, 1'b0);
    check("pre_reset_taken", 32'(branch_taken), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(mispredict_count), 32'd0);
    check("async_rst_taken", 32'(branch_taken), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_taken", 32'(branch_taken), 32'd0);
    upd(32'h104, 1'b1, 1'b0);
    check("post_rst_weak_nt", 32'(branch_taken), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
